// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Stalls the pipeline while the operation is in flight and returns {remainder, quotient}.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_dvd_q, sgn_dvd_d;
  logic               sgn_dvs_q, sgn_dvs_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     partial;
  logic               trial_ge;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // The quotient register starts out holding the dividend; its MSB feeds the partial remainder.
  assign partial  = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (partial >= {1'b0, dvs_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sgn_dvd_d = sgn_dvd_q;
    sgn_dvs_d = sgn_dvs_q;
    signed_d  = signed_q;
    result_d  = result_q;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          if (divisor_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d   = ON;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = abs_val(dividend_i, signed_i);
            dvs_d     = abs_val(divisor_i, signed_i);
            sgn_dvd_d = dividend_i[WIDTH-1];
            sgn_dvs_d = divisor_i[WIDTH-1];
            signed_d  = signed_i;
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = '0;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = END;
          result_d = {cond_neg(rem_q, signed_q && sgn_dvd_q),
                      cond_neg(quo_q, signed_q && (sgn_dvd_q ^ sgn_dvs_q))};
        end else begin
          rem_d = trial_ge ? WIDTH'(partial - {1'b0, dvs_q}) : partial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], trial_ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dvs_q <= sgn_dvs_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
    end
  end

  // Stall drops in END so EX advances in the same cycle it sees ready_o.
  assign result_o   = result_q;
  assign ready_o    = (state_q == END);
  assign busy_o     = (state_q == BYZERO) || (state_q == ON);
  assign stallreq_o = ((state_q == FREE) && start_i && !annul_i) || busy_o;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed DIV/DIVU vectors, annul, hold and async reset.
module tb_ex_div;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [W-1:0]   dividend_i = '0;
  logic [W-1:0]   divisor_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;
  logic           stallreq_o;

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] sb_q[$];
  logic           ready_prev = 1'b0;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .annul_i(annul_i),
    .signed_i(signed_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .result_o(result_o),
    .ready_o(ready_o),
    .busy_o(busy_o),
    .stallreq_o(stallreq_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    logic [2*W-1:0] e;
    if (ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h with no divide pending", result_o);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", result_o, e);
      end
    end
    ready_prev = ready_o;
  end

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [2*W-1:0] exp, input int exp_lat, input int hold,
                         input string name);
    int   lat;
    logic stall_ok;
    sb_q.push_back(exp);
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sg;
    dividend_i = a;
    divisor_i  = b;
    #1;
    chk({name, "_stall_req"}, 64'(stallreq_o), 64'd1);
    @(posedge clk);
    lat      = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    dividend_i = $urandom;
    divisor_i  = $urandom;
    signed_i   = ~sg;
    while (!ready_o && lat < 100) begin
      stall_ok &= stallreq_o;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall_held"}, 64'(stall_ok), 64'd1);
    chk({name, "_stall_end"}, 64'(stallreq_o), 64'd0);
    chk({name, "_busy_end"}, 64'(busy_o), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      chk({name, "_hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({name, "_ready_clr"}, 64'(ready_o), 64'd0);
    chk({name, "_result_clr"}, result_o, 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic never_ready;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(stallreq_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5, "divu_100_7");
    run_div(-32'sd7, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0, "div_m7_2");
    run_div(32'd7, -32'sd2, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 0, "div_7_m2");
    run_div(32'd5, 32'd0, 1'b0, 64'd0, 1, 0, "divu_by0");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 0, "div_ovf");
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, {32'h0000000F, 32'h0FFFFFFF}, 33, 0, "divu_max");

    // Annul mid-operation: no result may ever appear.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_busy_after", 64'(busy_o), 64'd0);
    chk("annul_stall_after", 64'(stallreq_o), 64'd0);
    chk("annul_ready_after", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    never_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) never_ready = 1'b0;
    end
    chk("annul_no_ready", 64'(never_ready), 64'd1);
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0, "divu_9_3");

    // Asynchronous reset between edges mid-operation.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd12345;
    divisor_i  = 32'd10;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_busy_before", 64'(busy_o), 64'd1);
    #1;
    start_i = 1'b0;
    rst     = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_stall", 64'(stallreq_o), 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, 0, "divu_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
